seq_adder64_ctrl: RTL and testbench

//   Multi-cycle 64-bit adder controller. Accepts one 64-bit operand pair per transaction over a

---
 rtl/seq_adder64_ctrl.sv | 139 +++++++++++++
 tb/tb_seq_adder64_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder64_ctrl.sv
// Multi-cycle wide adder controller: streams 16-bit operand slices (LSB first) through an
// external 16-bit adder, chains its carry, and assembles a registered sum, carry-out and overflow.
module seq_adder64_ctrl #(
    parameter int NUM_SLICES = 4,
    parameter int SETTLE     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*NUM_SLICES-1:0] in_a,
    input  logic [16*NUM_SLICES-1:0] in_b,
    input  logic                    in_cin,
    output logic [15:0]             add_a,
    output logic [15:0]             add_b,
    output logic                    add_cin,
    input  logic [15:0]             add_s,
    input  logic                    add_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*NUM_SLICES-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_ovf
);

    localparam int W     = 16 * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
    localparam logic [3:0]       SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      a_slice, b_slice;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slice select uses only registered operands and index, so add_* never sees an input path.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_slice = a_q[16*i +: 16];
                b_slice = b_q[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    cnt_d   = SETTLE_C;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_d[16*i +: 16] = add_s;
                        end
                    end
                    carry_d = add_cout;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        cout_d  = add_cout;
                        ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[15] != a_q[W-1]);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = SETTLE_C;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign add_a     = (state_q == RUN) ? a_slice : 16'd0;
    assign add_b     = (state_q == RUN) ? b_slice : 16'd0;
    assign add_cin   = (state_q == RUN) ? carry_q : 1'b0;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_adder64_ctrl.sv
// Directed bench for seq_adder64_ctrl: one instance with SETTLE=2, one with SETTLE=0,
// each driven by an ideal 16-bit adder model.
module tb_seq_adder64_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] in_a      [2];
    logic [63:0] in_b      [2];
    logic        in_cin    [2];
    logic [15:0] add_a     [2];
    logic [15:0] add_b     [2];
    logic        add_cin   [2];
    logic [15:0] add_s     [2];
    logic        add_cout  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_sum   [2];
    logic        out_cout  [2];
    logic        out_ovf   [2];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] seen_a[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_adder
        assign {add_cout[gi], add_s[gi]} = {1'b0, add_a[gi]} + {1'b0, add_b[gi]} + {16'd0, add_cin[gi]};
    end

    seq_adder64_ctrl #(.NUM_SLICES(4), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_s(add_s[0]), .add_cout(add_cout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
    );

    seq_adder64_ctrl #(.NUM_SLICES(4), .SETTLE(0)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_s(add_s[1]), .add_cout(add_cout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the instance idle; ends at the negedge where out_valid is first seen.
    task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic [63:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                          input int exp_lat, input bit chk_cin, input string tag);
        int n;
        seen_a.delete();
        in_a[d]     = a;
        in_b[d]     = b;
        in_cin[d]   = cin;
        in_valid[d] = 1'b1;
        chk({tag, "_in_ready_idle"}, in_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_a[d]     = {$urandom, $urandom};
        in_b[d]     = {$urandom, $urandom};
        in_cin[d]   = ~cin;
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 40) begin
            seen_a.push_back(add_a[d]);
            if (chk_cin) chk({tag, "_add_cin"}, add_cin[d], 1'b1);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_out_valid"}, out_valid[d], 1'b1);
        chk({tag, "_in_ready_done"}, in_ready[d], 1'b0);
        chk({tag, "_sum"}, out_sum[d], exp_sum);
        chk({tag, "_cout"}, out_cout[d], exp_cout);
        chk({tag, "_ovf"}, out_ovf[d], exp_ovf);
        chk({tag, "_add_a_idle"}, add_a[d], 16'd0);
        $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, a, b, cin, out_sum[d], out_cout[d], out_ovf[d], n);
    endtask

    task automatic release_out(input int d, input string tag);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk({tag, "_rel_valid"}, out_valid[d], 1'b0);
        chk({tag, "_rel_ready"}, in_ready[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_a[d]      = '0;
            in_b[d]      = '0;
            in_cin[d]    = 1'b0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready[0], 1'b1);
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_out_sum", out_sum[0], 64'd0);
        chk("rst_out_cout", out_cout[0], 1'b0);
        chk("rst_out_ovf", out_ovf[0], 1'b0);
        chk("rst_add_a", add_a[0], 16'd0);
        chk("rst_add_b", add_b[0], 16'd0);
        chk("rst_add_cin", add_cin[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with exact 12-cycle latency
        run_op(0, 64'h0000_0000_24D7_0000, 64'h0000_0000_041F_0000, 1'b0,
               64'h0000_0000_28F6_0000, 1'b0, 1'b0, 12, 1'b0, "t1");

        // Back-pressure: result held, second request ignored while DONE
        in_a[0]     = 64'h0123_4567_89AB_CDEF;
        in_b[0]     = 64'h1111_1111_1111_1111;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", out_valid[0], 1'b1);
            chk("bp_in_ready", in_ready[0], 1'b0);
            chk("bp_sum", out_sum[0], 64'h0000_0000_28F6_0000);
        end
        $display("op bp: held 20 cycles, sum=%h", out_sum[0]);
        release_out(0, "bp");
        run_op(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
               64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 12, 1'b0, "t4b");
        release_out(0, "t4b");

        // Carry ripples through every slice
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
               64'd0, 1'b1, 1'b0, 12, 1'b1, "t2");
        release_out(0, "t2");

        // Signed overflow cases
        run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 12, 1'b0, "t3a");
        release_out(0, "t3a");
        run_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'd0, 1'b1, 1'b1, 12, 1'b0, "t3b");
        release_out(0, "t3b");

        // Reset mid-operation, five clocks after accept
        in_a[0]     = 64'h1111_1111_1111_1111;
        in_b[0]     = 64'h1111_1111_1111_1111;
        in_cin[0]   = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid[0], 1'b0);
        chk("mid_rst_ready", in_ready[0], 1'b1);
        chk("mid_rst_sum", out_sum[0], 64'd0);
        chk("mid_rst_add_a", add_a[0], 16'd0);
        chk("mid_rst_add_b", add_b[0], 16'd0);
        chk("mid_rst_add_cin", add_cin[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) vcount++;
        end
        chk("mid_rst_no_valid", vcount, 0);
        $display("op rst: mid-operation reset, out_valid cycles afterwards=%0d", vcount);
        run_op(0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0,
               64'h2222_2222_2222_2222, 1'b0, 1'b0, 12, 1'b0, "t5");
        release_out(0, "t5");

        // SETTLE=0 instance: one cycle per slice
        run_op(1, 64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 1'b0,
               64'h0005_0005_0005_0005, 1'b0, 1'b0, 4, 1'b0, "t6");
        chk("t6_seq_len", seen_a.size(), 4);
        if (seen_a.size() == 4) begin
            chk("t6_add_a0", seen_a[0], 16'h0004);
            chk("t6_add_a1", seen_a[1], 16'h0003);
            chk("t6_add_a2", seen_a[2], 16'h0002);
            chk("t6_add_a3", seen_a[3], 16'h0001);
        end
        release_out(1, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
